axi_buffer_slice: RTL and testbench

Parametrised AXI4 buffering stage between one `AXI_BUS` slave port and one `AXI_BUS` master port. Each of the five channels (AW, W, B, AR, R) gets an independent FIFO of configurable depth, and depth 0 selects a wire pass-through. The block breaks long combinational valid/ready/payload paths between interconnect segments. It also decouples bursty masters from slow slaves, and reports per-channel occupancy and a global idle flag for power and clock-gating control.

---
 rtl/axi_buffer_slice_if.sv | 88 ++++++++
 rtl/axi_buffer_slice.sv | 168 ++++++++++++++++
 tb/tb_axi_buffer_slice.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_buffer_slice_if.sv
// rtl/axi_buffer_slice_if.sv - AXI4 bus bundle with Master and Slave modports
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_buffer_slice.sv
// rtl/axi_buffer_slice.sv - per-channel AXI4 FIFO slice with occupancy and idle reporting
module axi_buffer_slice_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign out_data_o     = in_data_i;
    assign out_valid_o    = in_valid_i;
    assign in_ready_o     = out_ready_i;
    assign cnt_o          = '0;
    assign empty_o        = 1'b1;
  end else begin : g_fifo
    localparam int unsigned     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    // Ready and valid depend only on registered count, so no comb path crosses the slice.
    assign in_ready_o  = !rst_i && (cnt_q != CNT_FULL);
    assign out_valid_o = !rst_i && (cnt_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign cnt_o       = cnt_q;
    assign empty_o     = (cnt_q == '0);

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // Payload storage is deliberately left unreset; valid qualifies it.
    always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
  end
endmodule

module axi_buffer_slice #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AW_DEPTH       = 2,
  parameter int unsigned W_DEPTH        = 2,
  parameter int unsigned B_DEPTH        = 2,
  parameter int unsigned AR_DEPTH       = 2,
  parameter int unsigned R_DEPTH        = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  AXI_BUS.Slave  slv,
  AXI_BUS.Master mst,
  output logic [((AW_DEPTH == 0) ? 1 : $clog2(AW_DEPTH + 1))-1:0] aw_cnt_o,
  output logic [((W_DEPTH  == 0) ? 1 : $clog2(W_DEPTH  + 1))-1:0] w_cnt_o,
  output logic [((B_DEPTH  == 0) ? 1 : $clog2(B_DEPTH  + 1))-1:0] b_cnt_o,
  output logic [((AR_DEPTH == 0) ? 1 : $clog2(AR_DEPTH + 1))-1:0] ar_cnt_o,
  output logic [((R_DEPTH  == 0) ? 1 : $clog2(R_DEPTH  + 1))-1:0] r_cnt_o,
  output logic idle_o
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned AX_W   = AXI_ADDR_WIDTH + 3 + 4 + 8 + 3 + 2 + 1 + 4 + 4
                                   + AXI_ID_WIDTH + AXI_USER_WIDTH;
  localparam int unsigned W_W    = AXI_DATA_WIDTH + STRB_W + AXI_USER_WIDTH + 1;
  localparam int unsigned B_W    = 2 + AXI_ID_WIDTH + AXI_USER_WIDTH;
  localparam int unsigned R_W    = AXI_DATA_WIDTH + 2 + 1 + AXI_ID_WIDTH + AXI_USER_WIDTH;

  logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [R_W-1:0]  r_in, r_out;
  logic aw_empty, w_empty, b_empty, ar_empty, r_empty;

  assign aw_in = {slv.aw_addr, slv.aw_prot, slv.aw_region, slv.aw_len, slv.aw_size,
                  slv.aw_burst, slv.aw_lock, slv.aw_cache, slv.aw_qos, slv.aw_id, slv.aw_user};
  assign {mst.aw_addr, mst.aw_prot, mst.aw_region, mst.aw_len, mst.aw_size,
          mst.aw_burst, mst.aw_lock, mst.aw_cache, mst.aw_qos, mst.aw_id, mst.aw_user} = aw_out;

  assign w_in = {slv.w_data, slv.w_strb, slv.w_user, slv.w_last};
  assign {mst.w_data, mst.w_strb, mst.w_user, mst.w_last} = w_out;

  assign b_in = {mst.b_resp, mst.b_id, mst.b_user};
  assign {slv.b_resp, slv.b_id, slv.b_user} = b_out;

  assign ar_in = {slv.ar_addr, slv.ar_prot, slv.ar_region, slv.ar_len, slv.ar_size,
                  slv.ar_burst, slv.ar_lock, slv.ar_cache, slv.ar_qos, slv.ar_id, slv.ar_user};
  assign {mst.ar_addr, mst.ar_prot, mst.ar_region, mst.ar_len, mst.ar_size,
          mst.ar_burst, mst.ar_lock, mst.ar_cache, mst.ar_qos, mst.ar_id, mst.ar_user} = ar_out;

  assign r_in = {mst.r_data, mst.r_resp, mst.r_last, mst.r_id, mst.r_user};
  assign {slv.r_data, slv.r_resp, slv.r_last, slv.r_id, slv.r_user} = r_out;

  axi_buffer_slice_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AX_W), .CNT_W($bits(aw_cnt_o))) i_aw_fifo (
    .clk_i, .rst_i,
    .in_data_i(aw_in),   .in_valid_i(slv.aw_valid), .in_ready_o(slv.aw_ready),
    .out_data_o(aw_out), .out_valid_o(mst.aw_valid), .out_ready_i(mst.aw_ready),
    .cnt_o(aw_cnt_o),    .empty_o(aw_empty)
  );

  axi_buffer_slice_fifo #(.DEPTH(W_DEPTH), .WIDTH(W_W), .CNT_W($bits(w_cnt_o))) i_w_fifo (
    .clk_i, .rst_i,
    .in_data_i(w_in),    .in_valid_i(slv.w_valid),  .in_ready_o(slv.w_ready),
    .out_data_o(w_out),  .out_valid_o(mst.w_valid), .out_ready_i(mst.w_ready),
    .cnt_o(w_cnt_o),     .empty_o(w_empty)
  );

  axi_buffer_slice_fifo #(.DEPTH(B_DEPTH), .WIDTH(B_W), .CNT_W($bits(b_cnt_o))) i_b_fifo (
    .clk_i, .rst_i,
    .in_data_i(b_in),    .in_valid_i(mst.b_valid),  .in_ready_o(mst.b_ready),
    .out_data_o(b_out),  .out_valid_o(slv.b_valid), .out_ready_i(slv.b_ready),
    .cnt_o(b_cnt_o),     .empty_o(b_empty)
  );

  axi_buffer_slice_fifo #(.DEPTH(AR_DEPTH), .WIDTH(AX_W), .CNT_W($bits(ar_cnt_o))) i_ar_fifo (
    .clk_i, .rst_i,
    .in_data_i(ar_in),   .in_valid_i(slv.ar_valid), .in_ready_o(slv.ar_ready),
    .out_data_o(ar_out), .out_valid_o(mst.ar_valid), .out_ready_i(mst.ar_ready),
    .cnt_o(ar_cnt_o),    .empty_o(ar_empty)
  );

  axi_buffer_slice_fifo #(.DEPTH(R_DEPTH), .WIDTH(R_W), .CNT_W($bits(r_cnt_o))) i_r_fifo (
    .clk_i, .rst_i,
    .in_data_i(r_in),    .in_valid_i(mst.r_valid),  .in_ready_o(mst.r_ready),
    .out_data_o(r_out),  .out_valid_o(slv.r_valid), .out_ready_i(slv.r_ready),
    .cnt_o(r_cnt_o),     .empty_o(r_empty)
  );

  assign idle_o = aw_empty && w_empty && b_empty && ar_empty && r_empty;
endmodule

// File: tb/tb_axi_buffer_slice.sv
// tb/tb_axi_buffer_slice.sv - self-checking bench for axi_buffer_slice
module tb_axi_buffer_slice;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned USER_W = 4;

  typedef logic [72:0] ax_t;
  typedef logic [40:0] wbeat_t;
  typedef logic [46:0] rbeat_t;

  typedef struct {
    logic       in_v;
    logic [7:0] id;
    logic       out_rdy;
    logic       e_in_rdy;
    logic       e_out_v;
    logic [7:0] e_id;
    logic [1:0] e_cnt;
    logic       e_idle;
  } r_vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [0:0] aw_cnt;
  logic [1:0] w_cnt;
  logic [0:0] b_cnt;
  logic [1:0] ar_cnt;
  logic [1:0] r_cnt;
  logic       idle;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(ADDR_W), .AXI_DATA_WIDTH(DATA_W),
            .AXI_ID_WIDTH(ID_W), .AXI_USER_WIDTH(USER_W)) slv_bus ();
  AXI_BUS #(.AXI_ADDR_WIDTH(ADDR_W), .AXI_DATA_WIDTH(DATA_W),
            .AXI_ID_WIDTH(ID_W), .AXI_USER_WIDTH(USER_W)) mst_bus ();

  axi_buffer_slice #(
    .AXI_ADDR_WIDTH(ADDR_W), .AXI_DATA_WIDTH(DATA_W),
    .AXI_ID_WIDTH(ID_W), .AXI_USER_WIDTH(USER_W),
    .AW_DEPTH(0), .W_DEPTH(2), .B_DEPTH(1), .AR_DEPTH(3), .R_DEPTH(3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .slv(slv_bus), .mst(mst_bus),
    .aw_cnt_o(aw_cnt), .w_cnt_o(w_cnt), .b_cnt_o(b_cnt),
    .ar_cnt_o(ar_cnt), .r_cnt_o(r_cnt), .idle_o(idle)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_signals();
    {slv_bus.aw_id, slv_bus.aw_addr, slv_bus.aw_len, slv_bus.aw_size, slv_bus.aw_burst,
     slv_bus.aw_lock, slv_bus.aw_cache, slv_bus.aw_prot, slv_bus.aw_qos, slv_bus.aw_region,
     slv_bus.aw_user, slv_bus.aw_valid} = '0;
    {slv_bus.w_data, slv_bus.w_strb, slv_bus.w_last, slv_bus.w_user, slv_bus.w_valid} = '0;
    slv_bus.b_ready = 1'b0;
    {slv_bus.ar_id, slv_bus.ar_addr, slv_bus.ar_len, slv_bus.ar_size, slv_bus.ar_burst,
     slv_bus.ar_lock, slv_bus.ar_cache, slv_bus.ar_prot, slv_bus.ar_qos, slv_bus.ar_region,
     slv_bus.ar_user, slv_bus.ar_valid} = '0;
    slv_bus.r_ready = 1'b0;
    mst_bus.aw_ready = 1'b0;
    mst_bus.w_ready  = 1'b0;
    {mst_bus.b_id, mst_bus.b_resp, mst_bus.b_user, mst_bus.b_valid} = '0;
    mst_bus.ar_ready = 1'b0;
    {mst_bus.r_id, mst_bus.r_data, mst_bus.r_resp, mst_bus.r_last, mst_bus.r_user,
     mst_bus.r_valid} = '0;
  endtask

  task automatic drive_ar(input ax_t v);
    {slv_bus.ar_addr, slv_bus.ar_prot, slv_bus.ar_region, slv_bus.ar_len, slv_bus.ar_size,
     slv_bus.ar_burst, slv_bus.ar_lock, slv_bus.ar_cache, slv_bus.ar_qos, slv_bus.ar_id,
     slv_bus.ar_user} = v;
  endtask

  function automatic ax_t ar_out();
    return {mst_bus.ar_addr, mst_bus.ar_prot, mst_bus.ar_region, mst_bus.ar_len, mst_bus.ar_size,
            mst_bus.ar_burst, mst_bus.ar_lock, mst_bus.ar_cache, mst_bus.ar_qos, mst_bus.ar_id,
            mst_bus.ar_user};
  endfunction

  task automatic drive_w(input wbeat_t v);
    {slv_bus.w_data, slv_bus.w_strb, slv_bus.w_user, slv_bus.w_last} = v;
  endtask

  function automatic wbeat_t w_out();
    return {mst_bus.w_data, mst_bus.w_strb, mst_bus.w_user, mst_bus.w_last};
  endfunction

  function automatic rbeat_t r_beat_of(input logic [7:0] id);
    return {24'h5A5A5A, id, id[1:0], id[0], id, id[3:0]};
  endfunction

  task automatic drive_r(input logic [7:0] id);
    {mst_bus.r_data, mst_bus.r_resp, mst_bus.r_last, mst_bus.r_id, mst_bus.r_user} = r_beat_of(id);
  endtask

  function automatic rbeat_t r_out();
    return {slv_bus.r_data, slv_bus.r_resp, slv_bus.r_last, slv_bus.r_id, slv_bus.r_user};
  endfunction

  r_vec_t     rtab[$];
  wbeat_t     wdat[16];
  ax_t        ar_tab[10];
  ax_t        ar_q[$];
  logic [7:0] b_q[$];
  ax_t        aw_v;
  logic       exp_v;
  int         sent, recv, b_in_hs, b_out_hs;
  logic [7:0] bid;

  initial begin
    init_signals();

    // Reset held with valids asserted: buffered readys/valids must stay low.
    rst = 1'b1;
    slv_bus.aw_valid = 1'b1;
    slv_bus.w_valid  = 1'b1;
    slv_bus.ar_valid = 1'b1;
    mst_bus.b_valid  = 1'b1;
    mst_bus.r_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_w_ready",     slv_bus.w_ready,  0);
      check("rst_ar_ready",    slv_bus.ar_ready, 0);
      check("rst_b_ready",     mst_bus.b_ready,  0);
      check("rst_r_ready",     mst_bus.r_ready,  0);
      check("rst_w_valid",     mst_bus.w_valid,  0);
      check("rst_ar_valid",    mst_bus.ar_valid, 0);
      check("rst_r_valid",     slv_bus.r_valid,  0);
      check("rst_idle",        idle,             1);
      check("rst_cnt",         {w_cnt, b_cnt, ar_cnt, r_cnt}, 0);
      check("rst_aw_pass_v",   mst_bus.aw_valid, 1);
      check("rst_aw_pass_rdy", slv_bus.aw_ready, 0);
    end
    rst = 1'b0;
    init_signals();
    #1;
    check("rel_w_ready",  slv_bus.w_ready,  1);
    check("rel_ar_ready", slv_bus.ar_ready, 1);
    check("rel_b_ready",  mst_bus.b_ready,  1);
    check("rel_r_ready",  mst_bus.r_ready,  1);
    step();

    // R channel, depth 3: fill, backpressure, single-cycle release, wrap, push+pop.
    rtab.push_back(r_vec_t'{1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0, 1'b1});
    rtab.push_back(r_vec_t'{1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 8'd1, 2'd1, 1'b0});
    rtab.push_back(r_vec_t'{1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 8'd1, 2'd2, 1'b0});
    rtab.push_back(r_vec_t'{1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 8'd1, 2'd3, 1'b0});
    rtab.push_back(r_vec_t'{1'b1, 8'd4, 1'b1, 1'b0, 1'b1, 8'd1, 2'd3, 1'b0});
    rtab.push_back(r_vec_t'{1'b1, 8'd4, 1'b0, 1'b1, 1'b1, 8'd2, 2'd2, 1'b0});
    rtab.push_back(r_vec_t'{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 2'd3, 1'b0});
    rtab.push_back(r_vec_t'{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd2, 2'd3, 1'b0});
    rtab.push_back(r_vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd3, 2'd2, 1'b0});
    rtab.push_back(r_vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd4, 2'd1, 1'b0});
    rtab.push_back(r_vec_t'{1'b1, 8'd5, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0, 1'b1});
    rtab.push_back(r_vec_t'{1'b1, 8'd6, 1'b1, 1'b1, 1'b1, 8'd5, 2'd1, 1'b0});
    rtab.push_back(r_vec_t'{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd6, 2'd1, 1'b0});
    rtab.push_back(r_vec_t'{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0, 1'b1});
    foreach (rtab[i]) begin
      mst_bus.r_valid = rtab[i].in_v;
      drive_r(rtab[i].id);
      slv_bus.r_ready = rtab[i].out_rdy;
      #1;
      check("r_in_ready",  mst_bus.r_ready, rtab[i].e_in_rdy);
      check("r_out_valid", slv_bus.r_valid, rtab[i].e_out_v);
      check("r_cnt",       r_cnt,           rtab[i].e_cnt);
      check("r_idle",      idle,            rtab[i].e_idle);
      if (rtab[i].e_out_v) check("r_payload", r_out(), r_beat_of(rtab[i].e_id));
      step();
    end
    init_signals();

    // W streaming through depth 2: 16 back-to-back beats, no bubbles.
    for (int k = 0; k < 16; k++) begin
      wdat[k] = {$urandom(), 4'($urandom()), 4'($urandom()), 1'b0};
      wdat[k][0] = (k == 15);
    end
    for (int cyc = 0; cyc < 18; cyc++) begin
      slv_bus.w_valid = (cyc < 16);
      if (cyc < 16) drive_w(wdat[cyc]);
      mst_bus.w_ready = 1'b1;
      #1;
      exp_v = (cyc >= 1) && (cyc <= 16);
      if (cyc < 16) check("w_in_ready", slv_bus.w_ready, 1);
      check("w_out_valid", mst_bus.w_valid, exp_v);
      check("w_cnt",       w_cnt,           {1'b0, exp_v});
      if (exp_v) check("w_beat_order", w_out(), wdat[cyc-1]);
      step();
    end
    init_signals();

    // B depth 1: continuous traffic must alternate push and pop.
    bid = 8'd0;
    b_in_hs = 0;
    b_out_hs = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      mst_bus.b_valid = 1'b1;
      mst_bus.b_id    = bid;
      mst_bus.b_resp  = bid[1:0];
      slv_bus.b_ready = 1'b1;
      #1;
      check("b_in_ready_alt",  mst_bus.b_ready, (cyc % 2) == 0);
      check("b_out_valid_alt", slv_bus.b_valid, (cyc % 2) == 1);
      if (slv_bus.b_valid) begin
        if (b_q.size() == 0) check("b_spurious_out", slv_bus.b_id, 8'hxx);
        else check("b_order", {slv_bus.b_resp, slv_bus.b_id}, {b_q[0][1:0], b_q.pop_front()});
        b_out_hs++;
      end
      if (mst_bus.b_ready) begin
        b_q.push_back(bid);
        bid++;
        b_in_hs++;
      end
      step();
    end
    check("b_out_beats_20cyc", b_out_hs, 10);
    check("b_in_beats_20cyc",  b_in_hs,  10);
    init_signals();

    // AW pass-through: both directions combinational, count stuck at 0.
    for (int cyc = 0; cyc < 8; cyc++) begin
      aw_v = {$urandom(), 41'({$urandom(), $urandom()})};
      {slv_bus.aw_addr, slv_bus.aw_prot, slv_bus.aw_region, slv_bus.aw_len, slv_bus.aw_size,
       slv_bus.aw_burst, slv_bus.aw_lock, slv_bus.aw_cache, slv_bus.aw_qos, slv_bus.aw_id,
       slv_bus.aw_user} = aw_v;
      slv_bus.aw_valid = 1'($urandom());
      mst_bus.aw_ready = 1'($urandom());
      #1;
      check("aw_pass_valid", mst_bus.aw_valid, slv_bus.aw_valid);
      check("aw_pass_ready", slv_bus.aw_ready, mst_bus.aw_ready);
      check("aw_pass_payload",
            {mst_bus.aw_addr, mst_bus.aw_prot, mst_bus.aw_region, mst_bus.aw_len, mst_bus.aw_size,
             mst_bus.aw_burst, mst_bus.aw_lock, mst_bus.aw_cache, mst_bus.aw_qos, mst_bus.aw_id,
             mst_bus.aw_user}, aw_v);
      check("aw_cnt_zero", aw_cnt, 0);
      step();
    end
    init_signals();

    // AR depth 3 under random ready on both sides, checked against a queue model.
    for (int i = 0; i < 10; i++)
      ar_tab[i] = {$urandom(), 3'($urandom()), 4'($urandom()), 8'($urandom()), 3'($urandom()),
                   2'($urandom()), 1'($urandom()), 4'($urandom()), 4'($urandom()), 8'(i),
                   4'($urandom())};
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 600 && recv < 10; cyc++) begin
      slv_bus.ar_valid = (sent < 10) && ($urandom_range(0, 3) != 0);
      drive_ar(ar_tab[(sent < 10) ? sent : 9]);
      mst_bus.ar_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("ar_ready_model", slv_bus.ar_ready, ar_q.size() != 3);
      check("ar_cnt_model",   ar_cnt,           ar_q.size());
      check("ar_valid_model", mst_bus.ar_valid, ar_q.size() != 0);
      if (mst_bus.ar_valid && ar_q.size() != 0) check("ar_payload_order", ar_out(), ar_q[0]);
      if (mst_bus.ar_valid && mst_bus.ar_ready && ar_q.size() != 0) begin
        void'(ar_q.pop_front());
        recv++;
      end
      if (slv_bus.ar_valid && slv_bus.ar_ready) begin
        ar_q.push_back(ar_tab[sent]);
        sent++;
      end
      step();
    end
    check("ar_all_received", recv, 10);
    init_signals();
    #1;
    check("ar_idle_after", idle, 1);

    // Reset mid-burst: queued W beats are dropped and never emitted.
    slv_bus.w_valid = 1'b1;
    drive_w(41'h1_2345_6789_A);
    step();
    drive_w(41'h0_ABCD_EF01_5);
    step();
    slv_bus.w_valid = 1'b0;
    #1;
    check("mb_w_cnt_full",  w_cnt,           2);
    check("mb_w_ready_full", slv_bus.w_ready, 0);
    check("mb_idle_busy",   idle,            0);
    rst = 1'b1;
    step();
    check("mb_w_cnt_rst",   w_cnt,           0);
    check("mb_w_valid_rst", mst_bus.w_valid, 0);
    check("mb_idle_rst",    idle,            1);
    rst = 1'b0;
    #1;
    check("mb_w_ready_rel", slv_bus.w_ready, 1);
    mst_bus.w_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      check("mb_no_stale_beat", mst_bus.w_valid, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
